ads_multich_rx: RTL and testbench
=================================

ADS_MULTICH_RX -- requirements
Module: ads_multich_rx

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CH, default 4, SHALL set the number of parallel DOUT lanes sharing one DRDY (legal 1..8).
REQ-003 Parameter W, default 24, SHALL set the sample width in bits, signed two's complement, MSB first (legal 8..32).
REQ-004 Parameter AVG_LOG2, default 2, SHALL set the averaging depth as 2^AVG_LOG2 frames (legal 0..4); it is used only when ADS_RX_AVG_EN is defined.
REQ-005 Port clk, input, 1: serial bit clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: asynchronous active-high reset.
REQ-007 Port en, input, 1: receive enable.
REQ-008 Port drdy, input, 1: frame marker, already single-ended and synchronous to clk.
REQ-009 Port dout, input, CH: serial data; bit i belongs to channel i.
REQ-010 Port data, output, CH*W: packed samples; channel i occupies bits [i*W +: W].
REQ-011 Port valid, output, 1: one-cycle strobe marking a new data word.
REQ-012 Port frame_err, output, 1: one-cycle strobe on an aborted frame.
REQ-013 Port err_cnt, output, 8: saturating count of aborted frames.

Function
REQ-014 The block SHALL register drdy into drdy_q; a rise is defined as drdy=1 and drdy_q=0 while en=1.
REQ-015 The FSM SHALL have two states, IDLE and SHIFT, with a bit index counter k of width ceil(log2(W)).
REQ-016 IDLE->SHIFT: on a rise, capture dout as the MSB of every channel and set k=1.
REQ-017 In SHIFT without a rise: shift dout into each channel and increment k.
REQ-018 When the bit at k=W-1 has been shifted (the LSB), the frame SHALL complete and the FSM SHALL return to IDLE.
REQ-019 Latency: the MSB is sampled at cycle t0; the LSB at t0+W-1; valid=1 and data updated at t0+W.
REQ-020 A rise at t0+W SHALL be a legal back-to-back frame: valid for the old frame and MSB capture for the new frame happen in the same cycle.
REQ-021 A rise in SHIFT with k<W SHALL discard the partial frame, pulse frame_err, increment err_cnt (saturating at 255), and restart the frame with the current bit as MSB; no valid is produced.
REQ-022 en=0 in any state SHALL force IDLE next cycle, discard the partial frame, hold data, and produce no valid or frame_err.
REQ-023 data SHALL hold its last value between valid strobes.
REQ-024 All channels SHALL be shifted in lockstep; there is no per-channel framing.

Reset
REQ-025 Asserting rst SHALL immediately set: state=IDLE, k=0, drdy_q=1, data=0, valid=0, frame_err=0, err_cnt=0, shift registers and accumulators=0.
REQ-026 drdy_q=1 at reset SHALL ensure that drdy held high through reset release does not start a frame.
REQ-027 Reset asserted mid-frame SHALL produce no valid after release until a new rise occurs.

Configuration
REQ-028 Macro ADS_RX_AVG_EN defined: each channel SHALL accumulate 2^AVG_LOG2 completed frames in a W+AVG_LOG2 bit signed accumulator.
REQ-029 With ADS_RX_AVG_EN defined, on completion of the last frame of a group, data SHALL be the sum arithmetically shifted right by AVG_LOG2 (floor), and valid SHALL pulse once per group.
REQ-030 With ADS_RX_AVG_EN defined, aborted frames SHALL not count toward the group, and en=0 or rst SHALL clear the group.
REQ-031 Macro ADS_RX_AVG_EN undefined: there SHALL be no accumulator logic, and valid SHALL pulse for every completed frame.

Verification (CH=2, W=24, AVG_LOG2=2)
REQ-032 Frame ch0=0x7FFFFF, ch1=0x800000 -> valid exactly 24 cycles after the rise; data={0x800000,0x7FFFFF}; frame_err=0.
REQ-033 Two back-to-back frames (second rise at t0+24) 0x000001 then 0xFFFFFE -> two valids at t0+24 and t0+48 with the correct values.
REQ-034 Rise, then another rise at bit 10 followed by a full frame 0x123456 -> one frame_err, err_cnt=1, single valid with 0x123456.
REQ-035 en dropped at bit 5 of a frame and restored -> no valid, no frame_err, data unchanged; the next full frame is received correctly.
REQ-036 300 consecutive aborted frames -> err_cnt=255 and held; rst -> 0.
REQ-037 With ADS_RX_AVG_EN, frames -1, -2, -3, -4 on ch0 -> a single valid after the 4th frame with ch0=-3 (0xFFFFFD).

Source files
------------

// File: rtl/ads_multich_rx.sv
// ads_multich_rx: multi-lane serial ADC frame receiver sharing one drdy marker.
// Define ADS_RX_AVG_EN to average 2^AVG_LOG2 frames per channel before each valid.
module ads_multich_rx #(
   parameter int CH       = 4,
   parameter int W        = 24,
   parameter int AVG_LOG2 = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            drdy,
   input  logic [CH-1:0]   dout,
   output logic [CH*W-1:0] data,
   output logic            valid,
   output logic            frame_err,
   output logic [7:0]      err_cnt
);
   localparam int KW = $clog2(W);

   if (CH < 1 || CH > 8 || W < 8 || W > 32 || AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_param
      $error("ads_multich_rx: parameter out of range");
   end

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_n;
   logic [KW-1:0] k, k_n;
   logic drdy_q, rise, done, abort, fire;
   logic [W-2:0] sr [CH];
   logic [CH*W-1:0] word, out_word;

   assign rise = en && drdy && !drdy_q;

   always_comb begin
      state_n = state;
      k_n = k;
      done = 1'b0;
      abort = 1'b0;
      if (!en) begin
         state_n = IDLE;
         k_n = '0;
      end else if (rise) begin
         state_n = SHIFT;
         k_n = KW'(1);
         abort = state == SHIFT;
      end else if (state == SHIFT) begin
         if (k == KW'(W - 1)) begin
            state_n = IDLE;
            k_n = '0;
            done = 1'b1;
         end else begin
            k_n = k + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k <= '0;
         drdy_q <= 1'b1;
      end else begin
         state <= state_n;
         k <= k_n;
         drdy_q <= drdy;
      end
   end

   // The MSB lands in bit 0 and reaches the top after W-1 shifts; the LSB is taken live from dout.
   always_ff @(posedge clk or posedge rst) begin
      for (int c = 0; c < CH; c++) begin
         if (rst) sr[c] <= '0;
         else if (rise) sr[c] <= (W-1)'(dout[c]);
         else if (en && state == SHIFT) sr[c] <= {sr[c][W-3:0], dout[c]};
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_word
      assign word[c*W +: W] = {sr[c], dout[c]};
   end

`ifdef ADS_RX_AVG_EN
   localparam int AW = W + AVG_LOG2;
   localparam int GW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
   logic [CH*AW-1:0] acc, sum;
   logic [GW-1:0] grp;
   logic last;

   assign last = grp == GW'((1 << AVG_LOG2) - 1);
   assign fire = done && last;

   for (genvar c = 0; c < CH; c++) begin : g_avg
      logic signed [W-1:0] s;
      logic signed [AW-1:0] t;
      assign s = word[c*W +: W];
      assign t = $signed(acc[c*AW +: AW]) + s;
      assign sum[c*AW +: AW] = t;
      assign out_word[c*W +: W] = W'(t >>> AVG_LOG2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst || !en || fire) begin
         acc <= '0;
         grp <= '0;
      end else if (done) begin
         acc <= sum;
         grp <= grp + 1'b1;
      end
   end
`else
   assign fire = done;
   assign out_word = word;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
         valid <= 1'b0;
         frame_err <= 1'b0;
         err_cnt <= '0;
      end else begin
         valid <= fire;
         frame_err <= abort;
         if (fire) data <= out_word;
         if (abort && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_ads_multich_rx.sv
// tb_ads_multich_rx: directed checks of framing, back-to-back, abort, enable and saturation.
module tb_ads_multich_rx;
   logic clk = 1'b0;
   logic rst, en, drdy;
   logic [1:0] dout;
   logic [47:0] data;
   logic valid, frame_err;
   logic [7:0] err_cnt;
   int checks = 0;
   int errors = 0;

   ads_multich_rx #(.CH(2), .W(24), .AVG_LOG2(2)) dut (
      .clk(clk), .rst(rst), .en(en), .drdy(drdy), .dout(dout),
      .data(data), .valid(valid), .frame_err(frame_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Drives n bits of a frame (rise on bit 0), sampling 1 time unit after each edge.
   task automatic frame(input logic [23:0] a, input logic [23:0] b, input int n,
                        output int v, output int e);
      v = 0;
      e = 0;
      for (int i = 0; i < n; i++) begin
         drdy = (i == 0);
         dout = {b[23-i], a[23-i]};
         @(posedge clk);
         #1;
         v += int'(valid);
         e += int'(frame_err);
      end
      drdy = 1'b0;
   endtask

   task automatic idle(input int n, output int v, output int e);
      v = 0;
      e = 0;
      drdy = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         v += int'(valid);
         e += int'(frame_err);
      end
   endtask

   task automatic test_reset;
      int v;
      rst = 1'b1; en = 1'b1; drdy = 1'b1; dout = 2'b11;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (data !== 48'h0 || valid !== 1'b0 || frame_err !== 1'b0 || err_cnt !== 8'h0) begin
         errors++;
         $display("FAIL reset_state: data=%h valid=%b ferr=%b cnt=%0d want 0", data, valid, frame_err, err_cnt);
      end
      rst = 1'b0;
      v = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         v += int'(valid);
      end
      checks++;
      if (v !== 0) begin
         errors++;
         $display("FAIL drdy_high_release: valids=%0d want 0", v);
      end
      drdy = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      int v, e;
      frame(24'h7FFFFF, 24'h800000, 24, v, e);
      checks++;
      if (valid !== 1'b1 || v !== 1) begin
         errors++;
         $display("FAIL basic_valid: valid=%b count=%0d want 1/1", valid, v);
      end
      checks++;
      if (data !== {24'h800000, 24'h7FFFFF} || e !== 0) begin
         errors++;
         $display("FAIL basic_data: data=%h ferr=%0d want 8000007fffff/0", data, e);
      end
      idle(3, v, e);
      checks++;
      if (v !== 0 || data !== {24'h800000, 24'h7FFFFF}) begin
         errors++;
         $display("FAIL basic_hold: valids=%0d data=%h want 0/8000007fffff", v, data);
      end
   endtask

   task automatic test_back_to_back;
      int v, e;
      frame(24'h000001, 24'hABCDEF, 24, v, e);
      checks++;
      if (valid !== 1'b1 || v !== 1 || data !== {24'hABCDEF, 24'h000001}) begin
         errors++;
         $display("FAIL b2b_first: valid=%b count=%0d data=%h want 1/1/abcdef000001", valid, v, data);
      end
      frame(24'hFFFFFE, 24'h135790, 24, v, e);
      checks++;
      if (valid !== 1'b1 || v !== 1 || e !== 0 || data !== {24'h135790, 24'hFFFFFE}) begin
         errors++;
         $display("FAIL b2b_second: valid=%b count=%0d ferr=%0d data=%h want 1/1/0/135790fffffe", valid, v, e, data);
      end
      idle(2, v, e);
   endtask

   task automatic test_abort;
      int v, e;
      frame(24'hFFFFFF, 24'hFFFFFF, 10, v, e);
      checks++;
      if (v !== 0 || e !== 0) begin
         errors++;
         $display("FAIL abort_partial: valids=%0d ferr=%0d want 0/0", v, e);
      end
      frame(24'h123456, 24'h654321, 24, v, e);
      checks++;
      if (e !== 1 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL abort_err: ferr=%0d cnt=%0d want 1/1", e, err_cnt);
      end
      checks++;
      if (v !== 1 || valid !== 1'b1 || data !== {24'h654321, 24'h123456}) begin
         errors++;
         $display("FAIL abort_recover: count=%0d valid=%b data=%h want 1/1/654321123456", v, valid, data);
      end
      idle(2, v, e);
   endtask

   task automatic test_en_drop;
      int v, e, v2, e2;
      frame(24'h0F0F0F, 24'hF0F0F0, 5, v, e);
      en = 1'b0;
      idle(4, v2, e2);
      en = 1'b1;
      idle(30, v, e);
      checks++;
      if (v + v2 !== 0 || e + e2 !== 0 || data !== {24'h654321, 24'h123456} || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL en_drop: valids=%0d ferr=%0d data=%h cnt=%0d want 0/0/654321123456/1",
                  v + v2, e + e2, data, err_cnt);
      end
      frame(24'h2468AC, 24'hDB9753, 24, v, e);
      checks++;
      if (v !== 1 || e !== 0 || data !== {24'hDB9753, 24'h2468AC}) begin
         errors++;
         $display("FAIL en_restore: count=%0d ferr=%0d data=%h want 1/0/db97532468ac", v, e, data);
      end
      idle(2, v, e);
   endtask

   task automatic test_saturate;
      int v, e, tv, te;
      tv = 0;
      te = 0;
      for (int i = 0; i < 301; i++) begin
         frame(24'h0, 24'h0, 2, v, e);
         tv += v;
         te += e;
      end
      checks++;
      if (err_cnt !== 8'd255 || tv !== 0 || te !== 300) begin
         errors++;
         $display("FAIL saturate: cnt=%0d valids=%0d ferr=%0d want 255/0/300", err_cnt, tv, te);
      end
      frame(24'h0, 24'h0, 2, v, e);
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++;
         $display("FAIL saturate_hold: cnt=%0d want 255", err_cnt);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (err_cnt !== 8'd0 || data !== 48'h0) begin
         errors++;
         $display("FAIL saturate_rst: cnt=%0d data=%h want 0/0", err_cnt, data);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset_midframe;
      int v, e;
      frame(24'hFFFFFF, 24'hFFFFFF, 12, v, e);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(30, v, e);
      checks++;
      if (v !== 0 || e !== 0 || data !== 48'h0) begin
         errors++;
         $display("FAIL reset_midframe: valids=%0d ferr=%0d data=%h want 0/0/0", v, e, data);
      end
      frame(24'h00ABCD, 24'h800001, 24, v, e);
      checks++;
      if (v !== 1 || data !== {24'h800001, 24'h00ABCD}) begin
         errors++;
         $display("FAIL reset_next: count=%0d data=%h want 1/80000100abcd", v, data);
      end
   endtask

   task automatic test_avg;
      int v, e, tv;
      tv = 0;
      frame(24'hFFFFFF, 24'd1, 24, v, e); tv += v;
      frame(24'hFFFFFE, 24'd2, 24, v, e); tv += v;
      frame(24'hFFFFFD, 24'd3, 24, v, e); tv += v;
      frame(24'hFFFFFC, 24'd5, 24, v, e); tv += v;
      checks++;
      if (tv !== 1 || valid !== 1'b1) begin
         errors++;
         $display("FAIL avg_valid: count=%0d valid=%b want 1/1", tv, valid);
      end
      checks++;
      if (data !== {24'd2, 24'hFFFFFD}) begin
         errors++;
         $display("FAIL avg_data: data=%h want 000002fffffd", data);
      end
      idle(2, v, e);
   endtask

   initial begin
      test_reset;
`ifdef ADS_RX_AVG_EN
      test_avg;
`else
      test_basic;
      test_back_to_back;
      test_abort;
      test_en_drop;
      test_saturate;
      test_reset_midframe;
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
